// File: rtl/gate_op_arbiter_pkg.sv
// Shared definitions for the gate-op arbiter: opcodes, FSM encoding and the
// round-robin winner selection used when sampling requests in IDLE.
package gate_op_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_INV  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // First set bit scanning ptr, ptr+1, ... modulo n; only the low n bits
    // of req take part, so one function serves every legal N_REQ.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0] ptr,
                                           input int n);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && !found && req[idx]) begin
                win   = 3'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/gate_op_arbiter_if.sv
// Requester-side bus of the gate-op arbiter, bundling request levels,
// packed per-requester operands and the grant/done/result returns.
interface gate_op_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    // Handshake: a requester raises req_in[i] with op/a/b stable and holds
    // them until gnt_out[i]; operands are captured on the grant edge, so
    // later changes are ignored. done_out[i] pulses for one cycle with
    // y_out valid; req_in[i] still high in the following IDLE is a new request.
    logic [N_REQ-1:0]       req_in;
    logic [3*N_REQ-1:0]     op_in;
    logic [WIDTH*N_REQ-1:0] a_in;
    logic [WIDTH*N_REQ-1:0] b_in;
    logic [N_REQ-1:0]       gnt_out;
    logic [N_REQ-1:0]       done_out;
    logic [WIDTH-1:0]       y_out;
    logic                   busy_out;
    logic [CNT_W-1:0]       op_cnt_out;

    modport master (
        output req_in, op_in, a_in, b_in,
        input  gnt_out, done_out, y_out, busy_out, op_cnt_out
    );

    modport slave (
        input  req_in, op_in, a_in, b_in,
        output gnt_out, done_out, y_out, busy_out, op_cnt_out
    );

endinterface

// File: rtl/gate_op_arbiter_logic_unit.sv
// Shared WIDTH-bit bitwise logic unit; purely combinational, one opcode per
// cycle. b_i is don't-care for INV and BUF.
module logic_unit
    import gate_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = a_i;
        case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_OR:   y_o = a_i | b_i;
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XOR:  y_o = a_i ^ b_i;
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_INV:  y_o = ~a_i;
            OP_BUF:  y_o = a_i;
        endcase
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter granting one requester at a time access to the shared
// logic unit: IDLE samples requests, EXEC evaluates, RESP pulses done.
module gate_op_arbiter
    import gate_op_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    gate_op_arbiter_if.slave   bus,
    output state_e             state_dbg_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_REQ-1:0] req_ext;
    logic [IDX_W-1:0]   pick;
    logic [WIDTH-1:0]   lu_y;

    assign req_ext = MAX_REQ'(bus.req_in);
    assign pick    = IDX_W'(rr_pick(req_ext, 3'(ptr_q), N_REQ));

    // The unit only ever sees latched operands, so requesters may change
    // their inputs freely once granted.
    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (lu_y)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        gnt_d   = '0;
        done_d  = '0;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_in) begin
                    win_d   = pick;
                    op_d    = bus.op_in[3*int'(pick) +: 3];
                    a_d     = bus.a_in[WIDTH*int'(pick) +: WIDTH];
                    b_d     = bus.b_in[WIDTH*int'(pick) +: WIDTH];
                    gnt_d   = N_REQ'(1) << pick;
                    ptr_d   = (int'(pick) == N_REQ - 1) ? '0 : pick + IDX_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                y_d     = lu_y;
                done_d  = N_REQ'(1) << win_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt_out    = gnt_q;
    assign bus.done_out   = done_q;
    assign bus.y_out      = y_q;
    assign bus.busy_out   = (state_q != ST_IDLE);
    assign bus.op_cnt_out = cnt_q;
    assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed plus random bench for gate_op_arbiter against a behavioural model
// of round-robin selection, bitwise results and the completion counter.
module tb_gate_op_arbiter;
    import gate_op_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst_n;
    state_e state_dbg;

    always #5 clk = ~clk;

    gate_op_arbiter_if #(.N_REQ(N), .WIDTH(W), .CNT_W(CW)) bus ();

    gate_op_arbiter #(
        .N_REQ (N),
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .bus           (bus.slave),
        .state_dbg_out (state_dbg)
    );

    // ---------------- scoreboard / model state ----------------
    int           total = 0;
    int           bad   = 0;
    int           mptr  = 0;
    int           mcnt  = 0;
    logic [W-1:0] my_y  = '0;
    logic [W-1:0] exp_q[$];
    logic [N-1:0] last_gnt;

    logic [2:0]   op_v[N];
    logic [W-1:0] a_v[N];
    logic [W-1:0] b_v[N];

    function automatic logic [W-1:0] ref_op(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_operands();
        for (int i = 0; i < N; i++) begin
            bus.op_in[3*i +: 3] = op_v[i];
            bus.a_in[W*i +: W]  = a_v[i];
            bus.b_in[W*i +: W]  = b_v[i];
        end
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < N; i++) begin
            op_v[i] = 3'($urandom_range(0, 7));
            a_v[i]  = W'($urandom);
            b_v[i]  = W'($urandom);
        end
        apply_operands();
    endtask

    // Entered at a negedge with the DUT idle; leaves at the negedge of the
    // following IDLE cycle, so back-to-back calls give a grant every 3 cycles.
    task automatic do_op(input logic [N-1:0] req, input bit hold, input string tag);
        int w;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && req[(mptr + k) % N]) w = (mptr + k) % N;
        mptr = (w + 1) % N;
        exp_q.push_back(ref_op(op_v[w], a_v[w], b_v[w]));
        bus.req_in = req;

        @(negedge clk);
        last_gnt = bus.gnt_out;
        check({tag, ":gnt"}, 32'(bus.gnt_out), 32'(1 << w));
        check({tag, ":busy_exec"}, 32'(bus.busy_out), 32'd1);
        check({tag, ":done_exec"}, 32'(bus.done_out), 32'd0);
        if (!hold) bus.req_in = '0;
        randomize_operands();

        @(negedge clk);
        my_y = exp_q.pop_front();
        check({tag, ":done"}, 32'(bus.done_out), 32'(1 << w));
        check({tag, ":gnt_resp"}, 32'(bus.gnt_out), 32'd0);
        check({tag, ":y"}, 32'(bus.y_out), 32'(my_y));

        @(negedge clk);
        mcnt = (mcnt + 1) % (1 << CW);
        check({tag, ":cnt"}, 32'(bus.op_cnt_out), 32'(mcnt));
        check({tag, ":busy_idle"}, 32'(bus.busy_out), 32'd0);
        check({tag, ":state"}, 32'(state_dbg), 32'(ST_IDLE));
        check({tag, ":y_hold"}, 32'(bus.y_out), 32'(my_y));
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] sweep_exp[8];
    int           order[6];
    logic [N-1:0] rreq;

    initial begin
        sweep_exp = '{8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hA5};
        order     = '{0, 1, 2, 3, 0, 1};
        rst_n      = 1'b0;
        bus.req_in = '0;
        for (int i = 0; i < N; i++) begin
            op_v[i] = '0;
            a_v[i]  = '0;
            b_v[i]  = '0;
        end
        apply_operands();
        repeat (3) @(negedge clk);
        check("rst:gnt", 32'(bus.gnt_out), 32'd0);
        check("rst:done", 32'(bus.done_out), 32'd0);
        check("rst:y", 32'(bus.y_out), 32'd0);
        check("rst:busy", 32'(bus.busy_out), 32'd0);
        check("rst:cnt", 32'(bus.op_cnt_out), 32'd0);
        check("rst:state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // single AND on requester 0
        op_v[0] = 3'd0; a_v[0] = 8'hF0; b_v[0] = 8'h3C;
        apply_operands();
        do_op(4'b0001, 1'b0, "t1");
        check("t1:y_const", 32'(bus.y_out), 32'h30);
        check("t1:cnt_const", 32'(bus.op_cnt_out), 32'd1);

        // opcode sweep on requester 2
        for (int op = 0; op < 8; op++) begin
            op_v[2] = 3'(op); a_v[2] = 8'hA5; b_v[2] = 8'h0F;
            apply_operands();
            do_op(4'b0100, 1'b0, $sformatf("t2_op%0d", op));
            check($sformatf("t2_op%0d:const", op), 32'(bus.y_out), 32'(sweep_exp[op]));
        end

        // pointer moves past the last winner
        do_op(4'b0010, 1'b0, "t4a");
        do_op(4'b0011, 1'b0, "t4b");
        check("t4b:gnt0", 32'(last_gnt), 32'b0001);
        do_op(4'b0011, 1'b0, "t4c");
        check("t4c:gnt1", 32'(last_gnt), 32'b0010);

        // requester 3 withdraws and changes operands after grant
        do_op(4'b1000, 1'b0, "t5");

        // all four held continuously
        for (int i = 0; i < 6; i++) begin
            do_op(4'b1111, 1'b1, $sformatf("t3_%0d", i));
            check($sformatf("t3_%0d:order", i), 32'(last_gnt), 32'(1 << order[i]));
        end
        bus.req_in = '0;

        // reset during EXEC
        bus.req_in = 4'b0001;
        @(negedge clk);
        check("t6:busy_pre", 32'(bus.busy_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6:gnt", 32'(bus.gnt_out), 32'd0);
        check("t6:done", 32'(bus.done_out), 32'd0);
        check("t6:y", 32'(bus.y_out), 32'd0);
        check("t6:busy", 32'(bus.busy_out), 32'd0);
        check("t6:cnt", 32'(bus.op_cnt_out), 32'd0);
        mptr = 0; mcnt = 0; my_y = '0;
        bus.req_in = '0;
        @(negedge clk);
        check("t6:no_done", 32'(bus.done_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(4'b0100, 1'b0, "t6_after");

        // random traffic, long enough to wrap the 4-bit counter
        for (int i = 0; i < 24; i++) begin
            rreq = N'($urandom_range(1, (1 << N) - 1));
            do_op(rreq, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        // idle with no requests: nothing moves
        bus.req_in = '0;
        repeat (3) @(negedge clk);
        check("idle:busy", 32'(bus.busy_out), 32'd0);
        check("idle:gnt", 32'(bus.gnt_out), 32'd0);
        check("idle:y", 32'(bus.y_out), 32'(my_y));
        check("idle:cnt", 32'(bus.op_cnt_out), 32'(mcnt));

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
